// File: rtl/musica_pkg.sv
// Shared definitions for the tone path: frequency word width, system clock and FSM encoding.
package musica_pkg;

    localparam int FREQ_W = 32;
    localparam int CLK_HZ = 25_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        UPDATE = 2'd2
    } estado_t;

endpackage

// File: rtl/sincronizador_flanco.sv
// Brings an asynchronous input into clk domain (2-FF) and flags each rising edge.
// rise is high for one cycle, two clk edges after the pin change is first sampled.
module sincronizador_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = sig_in;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    // Decoded from registered bits so the counter sees it on the third clk after the pin.
    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/medidor_frecuencia.sv
// Counts rising edges of sig_in over a GATE_CYCLES window and reports edges*SCALE as Hz.
// First valid GATE_CYCLES+2 clk after en rises, then every GATE_CYCLES+1 clk; no backpressure.
module medidor_frecuencia #(
    parameter int CLK_HZ      = musica_pkg::CLK_HZ,
    parameter int GATE_CYCLES = 2_500_000,
    parameter int SCALE       = CLK_HZ / GATE_CYCLES,
    parameter int CNT_W       = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          sig_in,
    output logic [musica_pkg::FREQ_W-1:0] freq,
    output logic [CNT_W-1:0]              edges,
    output logic                          valid,
    output logic                          overflow,
    output logic                          no_signal
);
    import musica_pkg::*;

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  EDGE_MAX  = {CNT_W{1'b1}};
    localparam logic [FREQ_W-1:0] SCALE_V   = FREQ_W'(SCALE);

    logic rise;

    sincronizador_flanco u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise)
    );

    estado_t           state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [CNT_W-1:0]  edges_q, edges_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              no_signal_q, no_signal_d;
    logic [FREQ_W-1:0] edge_ext;

    assign edge_ext = {{(FREQ_W - CNT_W){1'b0}}, edge_cnt_q};

    always_comb begin
        state_d     = state_q;
        gate_cnt_d  = gate_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        freq_d      = freq_q;
        edges_d     = edges_q;
        overflow_d  = overflow_q;
        no_signal_d = no_signal_q;
        valid_d     = 1'b0;

        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (en) state_d = GATE;
            end
            GATE: begin
                if (!en) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else begin
                    if (rise && (edge_cnt_q != EDGE_MAX)) edge_cnt_d = edge_cnt_q + 1'b1;
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d    = UPDATE;
                        gate_cnt_d = '0;
                    end else begin
                        gate_cnt_d = gate_cnt_q + 1'b1;
                    end
                end
            end
            UPDATE: begin
                edges_d     = edge_cnt_q;
                freq_d      = edge_ext * SCALE_V;
                overflow_d  = (edge_cnt_q == EDGE_MAX);
                no_signal_d = (edge_cnt_q == '0);
                valid_d     = 1'b1;
                gate_cnt_d  = '0;
                // A rise landing in this cycle belongs to the window that starts next.
                edge_cnt_d  = (rise && en) ? CNT_W'(1) : '0;
                state_d     = en ? GATE : IDLE;
            end
            default: begin
                state_d    = IDLE;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            freq_q      <= '0;
            edges_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            no_signal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            freq_q      <= freq_d;
            edges_q     <= edges_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            no_signal_q <= no_signal_d;
        end
    end

    assign freq      = freq_q;
    assign edges     = edges_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;
    assign no_signal = no_signal_q;

endmodule

// File: tb/tb_medidor_frecuencia.sv
// Scoreboard bench for medidor_frecuencia with a short gate so the run stays small.
module tb_medidor_frecuencia;

    localparam int G     = 200;
    localparam int SCALE = 50;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             sig_in;
    logic [31:0]      freq;
    logic [CNT_W-1:0] edges;
    logic             valid;
    logic             overflow;
    logic             no_signal;

    medidor_frecuencia #(
        .CLK_HZ      (10_000),
        .GATE_CYCLES (G),
        .SCALE       (SCALE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .freq      (freq),
        .edges     (edges),
        .valid     (valid),
        .overflow  (overflow),
        .no_signal (no_signal)
    );

    always #20 clk = ~clk;

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        bit nos;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   half   = 0;   // half-period of the tone in clk cycles; 0 holds sig_in

    // Tone generator: toggles sig_in every 'half' cycles, holds it when half==0.
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (half == 0) begin
                ph = 0;
            end else begin
                ph++;
                if (ph >= half) begin
                    ph = 0;
                    sig_in = ~sig_in;
                end
            end
        end
    end

    // Monitor: every valid pulse is matched against the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid got valid=1 with edges=%0d required no valid", edges);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (int'(edges) < e.lo || int'(edges) > e.hi) begin
                        errors++;
                        $display("FAIL edges got %0d required %0d..%0d", edges, e.lo, e.hi);
                    end
                    checks++;
                    if (int'(freq) < e.lo * SCALE || int'(freq) > e.hi * SCALE ||
                        int'(freq) != int'(edges) * SCALE) begin
                        errors++;
                        $display("FAIL freq got %0d required %0d..%0d and edges*%0d", freq,
                                 e.lo * SCALE, e.hi * SCALE, SCALE);
                    end
                    checks++;
                    if (overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL overflow got %0b required %0b", overflow, e.ovf);
                    end
                    checks++;
                    if (no_signal !== e.nos) begin
                        errors++;
                        $display("FAIL no_signal got %0b required %0b", no_signal, e.nos);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push(input int n, input int lo, input int hi, input bit ovf, input bit nos);
        exp_t x;
        x.lo = lo; x.hi = hi; x.ovf = ovf; x.nos = nos;
        for (int i = 0; i < n; i++) exp_q.push_back(x);
    endtask

    task automatic wait_valids(input string name, input int n, input int budget);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (valid) got++;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d valids required %0d", name, got, n);
        end
    endtask

    task automatic run(input string name, input int h, input int n, input int lo, input int hi,
                       input bit ovf, input bit nos);
        half = h;
        repeat (40) @(negedge clk);
        push(n, lo, hi, ovf, nos);
        en = 1'b1;
        wait_valids(name, n, n * (G + 1) + 20);
        en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // en rises at a negedge; posedges are counted until valid is first seen.
    task automatic first_latency(input string name);
        int n;
        n = 0;
        en = 1'b1;
        while (n < 2 * G) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) break;
        end
        chk(name, n, G + 2);
        en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #5;
        chk("reset_freq", int'(freq), 0);
        chk("reset_edges", int'(edges), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_no_signal", int'(no_signal), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Period 20 clk: 10 edges per 200-cycle window, +/-1.
        run("tone_20", 10, 3, 9, 11, 1'b0, 1'b0);
        // Period 40 clk: 5 edges per window, +/-1.
        run("tone_40", 20, 2, 4, 6, 1'b0, 1'b0);

        // Held input: exact zero result, also first-valid latency.
        half = 0;
        repeat (40) @(negedge clk);
        push(1, 0, 0, 1'b0, 1'b1);
        first_latency("latency_const");

        // Abort mid-gate: no valid, last (zero) result retained.
        half = 20;
        repeat (40) @(negedge clk);
        en = 1'b1;
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_freq_held", int'(freq), 0);
        chk("abort_no_signal_held", int'(no_signal), 1);
        chk("abort_edges_held", int'(edges), 0);
        push(1, 4, 6, 1'b0, 1'b0);
        first_latency("latency_after_abort");

        // Toggle every clk: ~100 edges saturate a 4-bit counter at 15.
        run("saturate", 1, 2, 15, 15, 1'b1, 1'b0);

        // Async reset mid-gate with edges running clears everything at once.
        half = 10;
        repeat (40) @(negedge clk);
        en = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_freq", int'(freq), 0);
        chk("midreset_edges", int'(edges), 0);
        chk("midreset_valid", int'(valid), 0);
        chk("midreset_overflow", int'(overflow), 0);
        chk("midreset_no_signal", int'(no_signal), 0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        run("after_reset", 10, 1, 9, 11, 1'b0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
